// File: rtl/palette_arbiter_pkg.sv
// Shared types and constants for the palette lookup arbiter: default colour
// table, RGB word type, FSM state encoding and a width helper.
package palette_pkg;

    localparam int DEF_CH_W = 4;
    localparam int RGB_W    = 3 * DEF_CH_W;
    localparam int PAL_N    = 16;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [5:0]       pal_addr_t;   // {bank[1:0], idx[3:0]} at default sizing

    typedef enum logic {
        INIT,
        RUN
    } fsm_t;

    // Loaded into every bank by the INIT sequencer; {red,green,blue}, red in MSBs.
    localparam rgb_t DEFAULT_PAL [PAL_N] = '{
        12'h000, 12'hFFF, 12'hF00, 12'h0F0,
        12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
        12'h888, 12'h444, 12'hF80, 12'h840,
        12'hFCA, 12'h08F, 12'h8F8, 12'hCCC
    };

    // Select/ID fields stay at least one bit wide even for a single bank.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/palette_arbiter_if.sv
// Lookup, response and config bundle between sprite pipelines and the
// palette arbiter.
interface palette_if
    import palette_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BANK = 4,
    parameter int IDX_W    = 4,
    parameter int CH_W     = DEF_CH_W
);

    localparam int BANK_W = clog2_min1(NUM_BANK);
    localparam int ID_W   = clog2_min1(NUM_REQ);
    localparam int ADDR_W = BANK_W + IDX_W;
    localparam int PIX_W  = 3 * CH_W;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BANK_W-1:0] req_bank;
    logic [NUM_REQ*IDX_W-1:0]  req_idx;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [PIX_W-1:0]          rsp_rgb;

    logic                      cfg_we;
    logic [ADDR_W-1:0]         cfg_addr;
    logic [PIX_W-1:0]          cfg_rgb;

    logic                      init_done;

    modport master (
        output req_valid, req_bank, req_idx, cfg_we, cfg_addr, cfg_rgb,
        input  req_ready, rsp_valid, rsp_id, rsp_rgb, init_done
    );

    modport slave (
        input  req_valid, req_bank, req_idx, cfg_we, cfg_addr, cfg_rgb,
        output req_ready, rsp_valid, rsp_id, rsp_rgb, init_done
    );

endinterface

// File: rtl/palette_arbiter_rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr_i (wrapping)
// wins; returns a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    id_o,
    output logic               any_o
);

    logic            found_hi;
    logic [ID_W-1:0] pick_hi;
    logic            found_lo;
    logic [ID_W-1:0] pick_lo;

    // NOTE: every combinational output gets a default before any branch,
    // otherwise untaken paths would infer latches.
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        found_lo = 1'b0;
        pick_lo  = '0;
        // Descending scans leave the lowest matching index as the winner.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_i[i] && (ID_W'(i) >= ptr_i)) begin
                found_hi = 1'b1;
                pick_hi  = ID_W'(i);
            end
            if (valid_i[i] && (ID_W'(i) < ptr_i)) begin
                found_lo = 1'b1;
                pick_lo  = ID_W'(i);
            end
        end
    end

    always_comb begin
        any_o   = found_hi | found_lo;
        id_o    = found_hi ? pick_hi : pick_lo;
        grant_o = any_o ? (NUM_REQ'(1) << id_o) : '0;
    end

endmodule

// File: rtl/palette_arbiter.sv
// Palette RAM shared by NUM_REQ sprite pipelines: default-load sequencer,
// round-robin lookup arbitration, 3-stage read pipeline and a config write port.
module palette_arbiter
    import palette_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_BANK = 4,
    parameter int IDX_W    = 4,
    parameter int CH_W     = DEF_CH_W
) (
    input  logic     Clk,
    input  logic     Reset_n,
    palette_if.slave bus
);

    localparam int BANK_W = clog2_min1(NUM_BANK);
    localparam int ID_W   = clog2_min1(NUM_REQ);
    localparam int ADDR_W = BANK_W + IDX_W;
    localparam int PIX_W  = 3 * CH_W;
    localparam int DEPTH  = NUM_BANK * (2 ** IDX_W);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    fsm_t              state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              running;

    logic [NUM_REQ-1:0] arb_valid;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [BANK_W-1:0]  sel_bank;
    logic [IDX_W-1:0]   sel_idx;

    logic              s1_valid_q;
    logic [ID_W-1:0]   s1_id_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s2_valid_q;
    logic [ID_W-1:0]   s2_id_q;
    logic [PIX_W-1:0]  s2_rgb_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [PIX_W-1:0]  rsp_rgb_q;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic [3:0]        pal_sel;
    logic [PIX_W-1:0]  ram_q [DEPTH];

    // ------------------------------------------------------------------
    // Default-load sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == LAST_ADDR) begin
                    state_d    = RUN;
                    init_ptr_d = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign running = (state_q == RUN);

    // ------------------------------------------------------------------
    // Arbitration: no grants until the palette holds its defaults
    // ------------------------------------------------------------------
    assign arb_valid = running ? bus.req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .valid_i (arb_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .id_o    (gnt_id),
        .any_o   (gnt_any)
    );

    always_comb begin
        sel_bank = '0;
        sel_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_bank = bus.req_bank[i*BANK_W +: BANK_W];
                sel_idx  = bus.req_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Single RAM write port: sequencer during INIT, config port in RUN.
    // Config writes arriving during INIT are dropped, not queued.
    // ------------------------------------------------------------------
    always_comb begin
        pal_sel = 4'(init_ptr_q);
        wr_en   = 1'b0;
        wr_addr = init_ptr_q;
        wr_data = PIX_W'(DEFAULT_PAL[pal_sel]);
        if (!running) begin
            wr_en = 1'b1;
        end else if (bus.cfg_we && ({1'b0, bus.cfg_addr} < DEPTH_EXT)) begin
            wr_en   = 1'b1;
            wr_addr = bus.cfg_addr;
            wr_data = bus.cfg_rgb;
        end
    end

    // NOTE: the palette array and its read register carry no reset so they
    // map onto block RAM; INIT rewrites every entry after each reset anyway.
    // A read and a write to the same entry on one edge return the old word.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            ram_q[wr_addr] <= wr_data;
        end
        if ({1'b0, s1_addr_q} < DEPTH_EXT) begin
            s2_rgb_q <= ram_q[s1_addr_q];
        end else begin
            s2_rgb_q <= '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rgb_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= gnt_any;
            if (gnt_any) begin
                s1_id_q   <= gnt_id;
                s1_addr_q <= {sel_bank, sel_idx};
            end
            s2_valid_q  <= s1_valid_q;
            s2_id_q     <= s1_id_q;
            rsp_valid_q <= s2_valid_q;
            // Response fields hold their last values on idle cycles.
            if (s2_valid_q) begin
                rsp_id_q  <= s2_id_q;
                rsp_rgb_q <= s2_rgb_q;
            end
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rgb   = rsp_rgb_q;
    assign bus.init_done = running;

    a_grant_onehot: assert property (@(posedge Clk) disable iff (!Reset_n)
        $onehot0(gnt));
    a_grant_on_valid: assert property (@(posedge Clk) disable iff (!Reset_n)
        ((gnt & ~bus.req_valid) == '0));

endmodule
